// File: rtl/seq_chk_sata.sv
// Incrementing-pattern checker for SATA test-data streams: locks onto a ramp of
// constant STEP, then flags, counts and captures sequence breaks.
module seq_chk_sata #(
  parameter int DATA_W    = 8,
  parameter int STEP      = 1,
  parameter int LOCK_CNT  = 2,
  parameter int LOSS_CNT  = 4,
  parameter int ERR_CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 RST,
  input  logic                 clr,
  input  logic [DATA_W-1:0]    data_in,
  input  logic                 ack,
  output logic                 locked,
  output logic                 err,
  output logic [ERR_CNT_W-1:0] err_cnt,
  output logic                 first_err_vld,
  output logic [DATA_W-1:0]    first_err_exp,
  output logic [DATA_W-1:0]    first_err_got
);
  localparam int RUN_W  = $clog2(LOCK_CNT + 1);
  localparam int MISS_W = $clog2(LOSS_CNT + 1);

  typedef enum logic {SEARCH, LOCKED} state_t;

  state_t                state, state_nxt;
  logic                  have_prev, have_prev_nxt;
  logic [RUN_W-1:0]      run, run_nxt;
  logic [MISS_W-1:0]     miss, miss_nxt;
  logic [DATA_W-1:0]     exp, exp_nxt;
  logic                  err_nxt;
  logic [ERR_CNT_W-1:0]  err_cnt_nxt;
  logic                  fv_nxt;
  logic [DATA_W-1:0]     fe_nxt, fg_nxt;

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      state         <= SEARCH;
      have_prev     <= 1'b0;
      run           <= '0;
      miss          <= '0;
      exp           <= '0;
      err           <= 1'b0;
      err_cnt       <= '0;
      first_err_vld <= 1'b0;
      first_err_exp <= '0;
      first_err_got <= '0;
    end else begin
      state         <= state_nxt;
      have_prev     <= have_prev_nxt;
      run           <= run_nxt;
      miss          <= miss_nxt;
      exp           <= exp_nxt;
      err           <= err_nxt;
      err_cnt       <= err_cnt_nxt;
      first_err_vld <= fv_nxt;
      first_err_exp <= fe_nxt;
      first_err_got <= fg_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    have_prev_nxt = have_prev;
    run_nxt       = run;
    miss_nxt      = miss;
    exp_nxt       = exp;
    err_nxt       = 1'b0;
    err_cnt_nxt   = err_cnt;
    fv_nxt        = first_err_vld;
    fe_nxt        = first_err_exp;
    fg_nxt        = first_err_got;
    if (clr) begin
      // clr beats a simultaneous ack: the word is dropped
      state_nxt     = SEARCH;
      have_prev_nxt = 1'b0;
      run_nxt       = '0;
      miss_nxt      = '0;
      err_cnt_nxt   = '0;
      fv_nxt        = 1'b0;
      fe_nxt        = '0;
      fg_nxt        = '0;
    end else if (ack) begin
      // exp always tracks the received word, so a glitch resyncs immediately
      exp_nxt = data_in + DATA_W'(STEP);
      case (state)
        SEARCH: begin
          if (!have_prev) begin
            have_prev_nxt = 1'b1;
            run_nxt       = '0;
          end else if (data_in == exp) begin
            run_nxt = run + RUN_W'(1);
            if (run_nxt == RUN_W'(LOCK_CNT)) begin
              state_nxt = LOCKED;
              miss_nxt  = '0;
            end
          end else begin
            run_nxt = '0;
          end
        end
        LOCKED: begin
          if (data_in == exp) begin
            miss_nxt = '0;
          end else begin
            err_nxt  = 1'b1;
            if (err_cnt != '1) err_cnt_nxt = err_cnt + ERR_CNT_W'(1);
            miss_nxt = miss + MISS_W'(1);
            if (!first_err_vld) begin
              fv_nxt = 1'b1;
              fe_nxt = exp;
              fg_nxt = data_in;
            end
            if (miss_nxt == MISS_W'(LOSS_CNT)) begin
              state_nxt = SEARCH;
              run_nxt   = '0;
            end
          end
        end
        default: state_nxt = SEARCH;
      endcase
    end
  end

  assign locked = (state == LOCKED);
endmodule

// File: tb/tb_seq_chk_sata.sv
// Bench for seq_chk_sata: a default 8-bit instance and a 16-bit STEP=3 instance with a
// 4-bit error counter, both compared each cycle against a word-history reference model.
module tb_seq_chk_sata;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        clr0 = 1'b0, ack0 = 1'b0;
  logic [7:0]  d0 = '0;
  logic        locked0, err0, fv0;
  logic [15:0] cnt0;
  logic [7:0]  fe0, fg0;

  logic        clr1 = 1'b0, ack1 = 1'b0;
  logic [15:0] d1 = '0;
  logic        locked1, err1, fv1;
  logic [3:0]  cnt1;
  logic [15:0] fe1, fg1;

  seq_chk_sata u0 (
    .clk(clk), .RST(rst), .clr(clr0), .data_in(d0), .ack(ack0),
    .locked(locked0), .err(err0), .err_cnt(cnt0),
    .first_err_vld(fv0), .first_err_exp(fe0), .first_err_got(fg0)
  );

  seq_chk_sata #(.DATA_W(16), .STEP(3), .LOCK_CNT(2), .LOSS_CNT(4), .ERR_CNT_W(4)) u1 (
    .clk(clk), .RST(rst), .clr(clr1), .data_in(d1), .ack(ack1),
    .locked(locked1), .err(err1), .err_cnt(cnt1),
    .first_err_vld(fv1), .first_err_exp(fe1), .first_err_got(fg1)
  );

  // Reference: remembers the previous accepted word and counts streaks of good/bad steps.
  typedef struct {
    bit have_prev;
    int prev;
    bit locked;
    int streak;
    int misses;
    bit err;
    int cnt;
    bit fv;
    int fe;
    int fg;
  } m_t;

  m_t m0, m1;
  int n_chk = 0, n_fail = 0;
  int nerr_obs;
  int v;

  task automatic mstep(inout m_t m, input int w, input int st, input int lk, input int ls,
                       input int cmax, input bit c, input bit a, input int din);
    int mask, d, want;
    bit good;
    mask = (1 << w) - 1;
    d = din & mask;
    want = (m.prev + st) & mask;
    good = m.have_prev && (d == want);
    m.err = 1'b0;
    if (c) begin
      m = '{default: 0};
      return;
    end
    if (!a) return;
    if (!m.have_prev) begin
      m.have_prev = 1'b1;
      m.streak = 0;
    end else if (!m.locked) begin
      if (good) begin
        m.streak++;
        if (m.streak == lk) begin
          m.locked = 1'b1;
          m.misses = 0;
        end
      end else m.streak = 0;
    end else if (good) begin
      m.misses = 0;
    end else begin
      m.err = 1'b1;
      if (m.cnt < cmax) m.cnt++;
      m.misses++;
      if (!m.fv) begin
        m.fv = 1'b1;
        m.fe = want;
        m.fg = d;
      end
      if (m.misses == ls) begin
        m.locked = 1'b0;
        m.streak = 0;
      end
    end
    m.prev = d;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
    n_chk++;
    assert (got === expv) else begin
      n_fail++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, expv);
    end
  endtask

  task automatic cmp0(input string tag);
    chk({tag, ".locked0"}, 32'(locked0), 32'(m0.locked));
    chk({tag, ".err0"},    32'(err0),    32'(m0.err));
    chk({tag, ".cnt0"},    32'(cnt0),    32'(m0.cnt));
    chk({tag, ".fv0"},     32'(fv0),     32'(m0.fv));
    chk({tag, ".fe0"},     32'(fe0),     32'(m0.fe));
    chk({tag, ".fg0"},     32'(fg0),     32'(m0.fg));
  endtask

  task automatic cmp1(input string tag);
    chk({tag, ".locked1"}, 32'(locked1), 32'(m1.locked));
    chk({tag, ".err1"},    32'(err1),    32'(m1.err));
    chk({tag, ".cnt1"},    32'(cnt1),    32'(m1.cnt));
    chk({tag, ".fv1"},     32'(fv1),     32'(m1.fv));
    chk({tag, ".fe1"},     32'(fe1),     32'(m1.fe));
    chk({tag, ".fg1"},     32'(fg1),     32'(m1.fg));
  endtask

  // Drive one cycle on instance 0 just after a rising edge, check just after the next one.
  task automatic step0(input string tag, input bit c, input bit a, input int d);
    clr0 = c; ack0 = a; d0 = 8'(d);
    @(posedge clk);
    mstep(m0, 8, 1, 2, 4, 65535, c, a, d);
    #1;
    cmp0(tag);
    clr0 = 1'b0; ack0 = 1'b0;
  endtask

  task automatic step1(input string tag, input bit c, input bit a, input int d);
    clr1 = c; ack1 = a; d1 = 16'(d);
    @(posedge clk);
    mstep(m1, 16, 3, 2, 4, 15, c, a, d);
    #1;
    cmp1(tag);
    clr1 = 1'b0; ack1 = 1'b0;
  endtask

  initial begin
    m0 = '{default: 0};
    m1 = '{default: 0};
    #12 rst = 1'b0;
    cmp0("reset");
    cmp1("reset");
    @(posedge clk); #1;

    // 1: plain ramp, lock after the third word
    for (int i = 0; i <= 16; i++) begin
      step0("ramp", 1'b0, 1'b1, i);
      if (i == 1) chk("ramp.not_yet_locked", 32'(locked0), 32'd0);
      if (i == 2) chk("ramp.locked_3rd", 32'(locked0), 32'd1);
    end
    chk("ramp.no_err", 32'(cnt0), 32'd0);

    // 2: wrap through 0xFF -> 0x00
    step0("clr", 1'b1, 1'b0, 0);
    for (int i = 0; i < 10; i++) step0("wrap", 1'b0, 1'b1, (8'hFC + i) & 8'hFF);
    chk("wrap.locked", 32'(locked0), 32'd1);
    chk("wrap.no_err", 32'(cnt0), 32'd0);

    // 3: single glitch resyncs, second glitch keeps the first capture
    for (int i = 6; i <= 8'h21; i++) step0("pre_glitch", 1'b0, 1'b1, i);
    step0("glitch", 1'b0, 1'b1, 8'h55);
    chk("glitch.err", 32'(err0), 32'd1);
    chk("glitch.cnt", 32'(cnt0), 32'd1);
    chk("glitch.fe", 32'(fe0), 32'h22);
    chk("glitch.fg", 32'(fg0), 32'h55);
    chk("glitch.locked", 32'(locked0), 32'd1);
    for (int i = 8'h56; i <= 8'h5F; i++) step0("post_glitch", 1'b0, 1'b1, i);
    chk("post_glitch.err_low", 32'(err0), 32'd0);
    step0("glitch2", 1'b0, 1'b1, 8'h90);
    step0("glitch2", 1'b0, 1'b1, 8'h91);
    chk("glitch2.cnt", 32'(cnt0), 32'd2);
    chk("glitch2.fe_kept", 32'(fe0), 32'h22);

    // 4: four bad words drop lock; counter survives relock
    step0("clr", 1'b1, 1'b0, 0);
    for (int i = 8'h10; i <= 8'h14; i++) step0("loss_pre", 1'b0, 1'b1, i);
    for (int k = 0; k < 4; k++) begin
      step0("loss", 1'b0, 1'b1, 0);
      if (k == 2) chk("loss.still_locked", 32'(locked0), 32'd1);
    end
    chk("loss.unlocked", 32'(locked0), 32'd0);
    chk("loss.cnt", 32'(cnt0), 32'd4);
    for (int i = 8'h40; i <= 8'h42; i++) step0("relock", 1'b0, 1'b1, i);
    chk("relock.locked", 32'(locked0), 32'd1);
    chk("relock.cnt_kept", 32'(cnt0), 32'd4);

    // 5: gaps with garbage, then clr colliding with ack
    step0("clr", 1'b1, 1'b0, 0);
    v = 8'h30;
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(1, 0) == 1) begin
        step0("gaps", 1'b0, 1'b1, v);
        v = (v + 1) & 8'hFF;
      end else step0("gaps", 1'b0, 1'b0, int'($urandom));
    end
    chk("gaps.no_err", 32'(cnt0), 32'd0);
    step0("clr_ack", 1'b1, 1'b1, v);
    chk("clr_ack.locked", 32'(locked0), 32'd0);
    chk("clr_ack.cnt", 32'(cnt0), 32'd0);
    chk("clr_ack.fv", 32'(fv0), 32'd0);
    step0("after_clr", 1'b0, 1'b1, v + 1);
    step0("after_clr", 1'b0, 1'b1, v + 2);
    chk("after_clr.seed_only", 32'(locked0), 32'd0);

    // random stream: mostly ramp, occasional jumps and gaps
    v = int'($urandom) & 8'hFF;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(3, 0) != 0) begin
        if ($urandom_range(11, 0) == 0) v = int'($urandom) & 8'hFF;
        step0("rand", 1'b0, 1'b1, v);
        v = (v + 1) & 8'hFF;
      end else step0("rand", 1'b0, 1'b0, int'($urandom));
    end

    // 6: wide instance, error counter saturation, async reset mid-stream
    v = int'($urandom) & 16'hFFFF;
    for (int i = 0; i < 5; i++) begin
      step1("w_lock", 1'b0, 1'b1, v);
      v = (v + 3) & 16'hFFFF;
    end
    chk("w_lock.locked", 32'(locked1), 32'd1);
    nerr_obs = 0;
    for (int g = 0; g < 20; g++) begin
      v = (v + 16'h100) & 16'hFFFF;
      for (int k = 0; k < 3; k++) begin
        step1("w_glitch", 1'b0, 1'b1, v);
        if (err1 === 1'b1) nerr_obs++;
        v = (v + 3) & 16'hFFFF;
      end
    end
    chk("w_glitch.pulses", 32'(nerr_obs), 32'd20);
    chk("w_glitch.sat", 32'(cnt1), 32'd15);
    chk("w_glitch.locked", 32'(locked1), 32'd1);

    #2 rst = 1'b1;
    #1;
    m0 = '{default: 0};
    m1 = '{default: 0};
    cmp1("rst_async");
    chk("rst_async.cnt", 32'(cnt1), 32'd0);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      step1("w_relock", 1'b0, 1'b1, v);
      v = (v + 3) & 16'hFFFF;
      if (i == 1) chk("w_relock.not_yet", 32'(locked1), 32'd0);
      if (i == 2) chk("w_relock.locked", 32'(locked1), 32'd1);
    end

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule
